// File: rtl/avalon_input_pio.sv
// Avalon-MM input PIO: synchronises and debounces board inputs, captures edges
// and raises a maskable level interrupt for the CPU.
module avalon_input_pio #(
   parameter int               WIDTH           = 8,
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter bit               EDGE_RISE       = 1'b1,
   parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pins_in,
   input  logic             chipselect,
   input  logic [1:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd1;
   localparam logic [1:0] ADDR_EDGECAP = 2'd2;
   localparam logic [1:0] ADDR_RAW     = 2'd3;

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0] deb_q, deb_d;
   logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;

   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] ev;
   logic [WIDTH-1:0] w1c_mask;
   logic [31:0]      rd_mux;

   assign wr_en = chipselect & write;
   assign rd_en = chipselect & read;

   // Two-flop synchroniser on every raw pin.
   always_comb begin
      sync1_d = pins_in;
      sync_d  = sync1_q;
   end

   // Per-bit debounce: the debounced bit only follows the synchronised bit
   // after it has differed for DEBOUNCE_CYCLES consecutive cycles.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_deb
         logic [CW-1:0] cnt_q, cnt_d;
         logic          deb_bit_d;

         always_comb begin
            cnt_d     = cnt_q;
            deb_bit_d = deb_q[gi];
            if (sync_q[gi] == deb_q[gi]) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               deb_bit_d = sync_q[gi];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign deb_d[gi] = deb_bit_d;
      end
   endgenerate

   // Edge detection on the debounced state.
   always_comb begin
      deb_dly_d = deb_q;
      if (EDGE_RISE) begin
         ev = deb_q & ~deb_dly_q;
      end else begin
         ev = ~deb_q & deb_dly_q;
      end
   end

   always_comb begin
      irqmask_d = irqmask_q;
      w1c_mask  = '0;
      if (wr_en) begin
         case (address)
            ADDR_IRQMASK: irqmask_d = writedata[WIDTH-1:0];
            ADDR_EDGECAP: w1c_mask  = writedata[WIDTH-1:0];
            default:      ;
         endcase
      end
      // A new event on the same bit as a clearing write keeps the bit set.
      edgecap_d = (edgecap_q & ~w1c_mask) | ev;
      irq_d     = |(edgecap_q & irqmask_q);
   end

   // Read mux samples state before any same-cycle write lands.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux = 32'(deb_q);
         ADDR_IRQMASK: rd_mux = 32'(irqmask_q);
         ADDR_EDGECAP: rd_mux = 32'(edgecap_q);
         ADDR_RAW:     rd_mux = 32'(sync_q);
         default:      rd_mux = '0;
      endcase
      readdata_d = rd_en ? rd_mux : readdata_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= INIT_VALUE;
         sync_q     <= INIT_VALUE;
         deb_q      <= INIT_VALUE;
         deb_dly_q  <= INIT_VALUE;
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync_q     <= sync_d;
         deb_q      <= deb_d;
         deb_dly_q  <= deb_dly_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule
